// File: rtl/serial_rx_parser_if.sv
// Byte-in / value-out bundle for serial_rx_parser: UART receive strobe and data
// on one side, show-ahead valid/ready value stream on the other.
interface serial_rx_parser_if #(
  parameter int WIDTH = 32
);
  logic             rx_avail;
  logic [7:0]       rx_data;
  logic [WIDTH-1:0] out_value;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output rx_avail, rx_data, out_ready,
    input  out_value, out_valid
  );

  modport slave (
    input  rx_avail, rx_data, out_ready,
    output out_value, out_valid
  );
endinterface

// File: rtl/serial_rx_parser.sv
// Parses newline-terminated ASCII decimal numbers into a show-ahead value FIFO.
// Optional macro SERIAL_RX_ECHO_EN adds a one-byte echo path (cansend/echo).
module serial_rx_parser #(
  parameter int         WIDTH      = 32,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] TERM       = 8'h0A
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  serial_rx_parser_if.slave bus,
  output logic overflow,
  output logic dropped
`ifdef SERIAL_RX_ECHO_EN
  ,
  input  logic       cansend,
  output logic [8:0] echo
`endif
);
  localparam int              AW      = $clog2(FIFO_DEPTH);
  localparam logic [7:0]      CR      = 8'h0D;
  localparam logic [AW:0]     DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]     ONE     = (AW+1)'(1);
  localparam logic [AW-1:0]   PTR_ONE = AW'(1);
  localparam logic [WIDTH+3:0] TEN    = (WIDTH+4)'(10);
  localparam logic [WIDTH+3:0] MAXV   = {4'b0000, {WIDTH{1'b1}}};

  typedef enum logic [1:0] {IDLE, NUM, SKIP} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic             push, ovf_set;
  logic [WIDTH-1:0] push_val;
  logic [WIDTH:0]   step_num, step_first;

  logic             accept, is_digit, is_term, is_cr;
  logic [3:0]       digit_val;

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count, count_nxt;
  logic [WIDTH-1:0] head, head_nxt;
  logic             pop, full, push_ok, drop_set;

  // Saturating decimal shift-in; result is {saturated, value}.
  function automatic logic [WIDTH:0] acc_step(input logic [WIDTH-1:0] a,
                                              input logic [3:0] d);
    logic [WIDTH+3:0] wide;
    wide = {4'b0000, a} * TEN + {{WIDTH{1'b0}}, d};
    if (wide > MAXV)
      return {1'b1, {WIDTH{1'b1}}};
    return {1'b0, wide[WIDTH-1:0]};
  endfunction

  assign accept     = bus.rx_avail & enable;
  assign is_digit   = (bus.rx_data >= 8'h30) && (bus.rx_data <= 8'h39);
  assign is_term    = (bus.rx_data == TERM);
  assign is_cr      = (bus.rx_data == CR);
  assign digit_val  = bus.rx_data[3:0];
  assign step_num   = acc_step(acc, digit_val);
  assign step_first = acc_step('0, digit_val);

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    push      = 1'b0;
    push_val  = acc;
    ovf_set   = 1'b0;
    if (accept && !is_cr) begin
      unique case (state)
        IDLE: begin
          if (is_digit) begin
            state_nxt = NUM;
            acc_nxt   = step_first[WIDTH-1:0];
            ovf_set   = step_first[WIDTH];
          end else if (!is_term) begin
            state_nxt = SKIP;
          end
        end
        NUM: begin
          if (is_digit) begin
            acc_nxt = step_num[WIDTH-1:0];
            ovf_set = step_num[WIDTH];
          end else if (is_term) begin
            push      = 1'b1;
            acc_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            state_nxt = SKIP;
          end
        end
        SKIP: begin
          if (is_term) begin
            acc_nxt   = '0;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // FIFO: head mirrors mem[rd_ptr] while non-empty and keeps its last value when empty.
  assign pop      = bus.out_valid & bus.out_ready;
  assign full     = (count == DEPTH_C);
  assign push_ok  = push & (~full | pop);
  assign drop_set = push & full & ~pop;

  always_comb begin
    head_nxt = head;
    if (pop) begin
      if (count == ONE) begin
        if (push_ok)
          head_nxt = push_val;
      end else begin
        head_nxt = mem[rd_ptr + PTR_ONE];
      end
    end else if (push_ok && count == '0) begin
      head_nxt = push_val;
    end
  end

  always_comb begin
    count_nxt = count;
    if (push_ok && !pop)
      count_nxt = count + ONE;
    else if (!push_ok && pop)
      count_nxt = count - ONE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      acc      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      head     <= '0;
      overflow <= 1'b0;
      dropped  <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      count <= count_nxt;
      head  <= head_nxt;
      if (push_ok)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      if (ovf_set)
        overflow <= 1'b1;
      if (drop_set)
        dropped <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= push_val;
  end

  assign bus.out_valid = (count != '0);
  assign bus.out_value = head;

`ifdef SERIAL_RX_ECHO_EN
  logic [7:0] echo_byte;
  logic       echo_full;

  // A byte arriving while the holder is occupied is simply not echoed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      echo_full <= 1'b0;
    else if (echo_full && cansend)
      echo_full <= 1'b0;
    else if (!echo_full && accept)
      echo_full <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!echo_full && accept)
      echo_byte <= bus.rx_data;
  end

  assign echo = (echo_full && cansend) ? {echo_byte, 1'b1} : 9'd0;
`endif
endmodule

// File: tb/tb_serial_rx_parser.sv
// Bench for serial_rx_parser: vector table, hand sequences for FIFO corners and
// reset, then random bytes checked against a line-based reference model.
module tb_serial_rx_parser;
  localparam int         WIDTH = 32;
  localparam int         DEPTH = 4;
  localparam logic [7:0] TERM  = 8'h0A;
  localparam logic [7:0] CR    = 8'h0D;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic overflow, dropped;

  serial_rx_parser_if #(.WIDTH(WIDTH)) bus ();

`ifdef SERIAL_RX_ECHO_EN
  logic       cansend = 1'b0;
  logic [8:0] echo;
`endif

  serial_rx_parser #(.WIDTH(WIDTH), .FIFO_DEPTH(DEPTH), .TERM(TERM)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .bus      (bus.slave),
    .overflow (overflow),
    .dropped  (dropped)
`ifdef SERIAL_RX_ECHO_EN
    ,
    .cansend  (cansend),
    .echo     (echo)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: lines are collected as text and interpreted at the terminator.
  logic [31:0] mq[$];
  logic [7:0]  line[$];
  bit          m_ovf, m_drop;
  logic [31:0] m_head;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit all_digits();
    foreach (line[i])
      if (line[i] < 8'h30 || line[i] > 8'h39) return 1'b0;
    return 1'b1;
  endfunction

  // {exceeds, value} of the decimal text in line, saturated at 2^32-1
  function automatic logic [32:0] line_value();
    int     i;
    longint v;
    i = 0;
    v = 0;
    while (i < line.size() && line[i] == 8'h30) i++;
    if (line.size() - i > 10) return {1'b1, 32'hFFFF_FFFF};
    for (int j = i; j < line.size(); j++) v = v * 10 + longint'(line[j] - 8'h30);
    if (v > 64'h0000_0000_FFFF_FFFF) return {1'b1, 32'hFFFF_FFFF};
    return {1'b0, v[31:0]};
  endfunction

  task automatic model_reset();
    mq.delete();
    line.delete();
    m_ovf  = 1'b0;
    m_drop = 1'b0;
    m_head = '0;
  endtask

  task automatic model_edge(input bit av, input bit en, input logic [7:0] d, input bit rdy);
    logic [32:0] r;
    if (rdy && mq.size() > 0) void'(mq.pop_front());
    if (av && en && d != CR) begin
      if (d == TERM) begin
        if (line.size() > 0 && all_digits()) begin
          r = line_value();
          if (mq.size() < DEPTH) mq.push_back(r[31:0]);
          else m_drop = 1'b1;
        end
        line.delete();
      end else begin
        line.push_back(d);
        if (all_digits()) begin
          r = line_value();
          if (r[32]) m_ovf = 1'b1;
        end
      end
    end
    if (mq.size() > 0) m_head = mq[0];
  endtask

  task automatic step(input bit av, input logic [7:0] d, input bit rdy);
    @(negedge clk);
    bus.rx_avail  = av;
    bus.rx_data   = d;
    bus.out_ready = rdy;
    @(posedge clk);
    model_edge(av, enable, d, rdy);
    #1;
    check("model", {29'b0, bus.out_valid, bus.out_value, overflow, dropped},
          {29'b0, (mq.size() > 0), m_head, m_ovf, m_drop});
  endtask

  task automatic send_str(input string s, input bit rdy);
    for (int i = 0; i < s.len(); i++) step(1'b1, s[i], rdy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b0;
    bus.rx_avail  = 1'b0;
    bus.rx_data   = 8'h00;
    bus.out_ready = 1'b0;
    model_reset();
    #2;
    check("reset_state", {29'b0, bus.out_valid, bus.out_value, overflow, dropped}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    string       txt;
    int          n_out;
    logic [31:0] last;
    bit          ovf;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int          n;
    logic [7:0]  b;
    int          r;

    bus.rx_avail  = 1'b0;
    bus.rx_data   = 8'h00;
    bus.out_ready = 1'b0;
    enable        = 1'b1;

    vecs[0] = '{"123\n",               1, 32'd123,       1'b0};
    vecs[1] = '{"4294967295\n",        1, 32'hFFFF_FFFF, 1'b0};
    vecs[2] = '{"4294967296\n",        1, 32'hFFFF_FFFF, 1'b1};
    vecs[3] = '{"12a3\n45\015\n\n",    1, 32'd45,        1'b0};
    vecs[4] = '{"\n\n\015\n",          0, 32'd0,         1'b0};
    vecs[5] = '{"007\015\n",           1, 32'd7,         1'b0};
    vecs[6] = '{"x99999999999\n",      0, 32'd0,         1'b0};
    vecs[7] = '{"99999999999z\n",      0, 32'd0,         1'b1};

    foreach (vecs[k]) begin
      do_reset();
      n = 0;
      for (int i = 0; i < vecs[k].txt.len(); i++) begin
        step(1'b1, vecs[k].txt[i], 1'b1);
        if (bus.out_valid) n++;
      end
      for (int i = 0; i < 3; i++) begin
        step(1'b0, 8'h00, 1'b1);
        if (bus.out_valid) n++;
      end
      check($sformatf("vec%0d_count", k), 64'(n), 64'(vecs[k].n_out));
      check($sformatf("vec%0d_value", k), 64'(bus.out_value), 64'(vecs[k].last));
      check($sformatf("vec%0d_ovf", k), 64'(overflow), 64'(vecs[k].ovf));
    end

    // Full FIFO with no consumer: fifth value lost, then drain 1..4.
    do_reset();
    send_str("1\n2\n3\n4\n5\n", 1'b0);
    check("full_dropped", 64'(dropped), 64'd1);
    check("full_valid", 64'(bus.out_valid), 64'd1);
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("drain_%0d", k), 64'(bus.out_value), 64'(k));
      step(1'b0, 8'h00, 1'b1);
    end
    check("drain_empty", 64'(bus.out_valid), 64'd0);
    check("drain_hold", 64'(bus.out_value), 64'd4);

    // Push and pop on the same edge while full: nothing lost.
    do_reset();
    send_str("1\n2\n3\n4\n5", 1'b0);
    step(1'b1, TERM, 1'b1);
    check("fullpp_dropped", 64'(dropped), 64'd0);
    for (int k = 2; k <= 5; k++) begin
      check($sformatf("fullpp_%0d", k), 64'(bus.out_value), 64'(k));
      step(1'b0, 8'h00, 1'b1);
    end
    check("fullpp_empty", 64'(bus.out_valid), 64'd0);

    // Push and pop on the same edge with one entry.
    do_reset();
    send_str("8\n9", 1'b0);
    check("one_head", 64'(bus.out_value), 64'd8);
    step(1'b1, TERM, 1'b1);
    check("one_pp_valid", 64'(bus.out_valid), 64'd1);
    check("one_pp_value", 64'(bus.out_value), 64'd9);
    step(1'b0, 8'h00, 1'b1);
    check("one_pp_empty", 64'(bus.out_valid), 64'd0);

    // Reset mid-number discards the partial value.
    do_reset();
    send_str("98", 1'b0);
    do_reset();
    send_str("7\n", 1'b0);
    check("midreset_value", 64'(bus.out_value), 64'd7);
    check("midreset_flags", {62'b0, overflow, dropped}, 64'd0);
    step(1'b0, 8'h00, 1'b1);
    check("midreset_single", 64'(bus.out_valid), 64'd0);

    // Bytes are ignored while disabled.
    do_reset();
    enable = 1'b0;
    send_str("55\n", 1'b1);
    enable = 1'b1;
    check("disabled_none", 64'(bus.out_valid), 64'd0);
    send_str("6\n", 1'b0);
    check("enabled_value", 64'(bus.out_value), 64'd6);

`ifdef SERIAL_RX_ECHO_EN
    do_reset();
    cansend = 1'b0;
    step(1'b1, 8'h41, 1'b1);
    check("echo_hold", 64'(echo), 64'd0);
    step(1'b0, 8'h00, 1'b1);
    check("echo_hold2", 64'(echo), 64'd0);
    @(negedge clk);
    cansend = 1'b1;
    #1;
    check("echo_pulse", 64'(echo), 64'h083);
    @(posedge clk);
    model_edge(1'b0, enable, 8'h00, 1'b1);
    #1;
    check("echo_cleared", 64'(echo), 64'd0);
    cansend = 1'b0;
`endif

    // Random bytes, random enable and consumer, checked against the model.
    for (int blk = 0; blk < 6; blk++) begin
      do_reset();
      for (int c = 0; c < 400; c++) begin
        r = int'($urandom_range(0, 99));
        if (r < 60)      b = 8'h30 + 8'($urandom_range(0, 9));
        else if (r < 78) b = TERM;
        else if (r < 83) b = CR;
        else             b = 8'($urandom_range(0, 255));
        enable = ($urandom_range(0, 9) != 0);
        step(($urandom_range(0, 9) < 7), b, ($urandom_range(0, 1) == 1));
      end
      enable = 1'b1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_rx_parser.md
Name: serial_rx_parser

Overview:
Receive-side counterpart of the serial byte transmitter. It consumes the byte stream from the UART receiver (rx_avail strobe plus rx_data) and parses newline-terminated ASCII decimal numbers into binary values. Parsed values go into a small show-ahead FIFO with a valid/ready output handshake for the puzzle-solving logic. It sits between the UART receiver and the solver core, opposite the serial output path.

Parameters:
WIDTH, 32, bit width of parsed values and the accumulator result.
FIFO_DEPTH, 4, number of parsed values buffered; must be a power of 2, minimum 2.
TERM, 8'h0A, terminator byte that ends a number.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
enable  input  1  when low, incoming bytes are ignored
rx_avail  input  1  one-cycle strobe: rx_data is valid
rx_data  input  8  received byte
out_value  output  WIDTH  FIFO head value
out_valid  output  1  FIFO non-empty
out_ready  input  1  consumer accepts head this cycle
overflow  output  1  sticky: a value exceeded 2^WIDTH-1
dropped  output  1  sticky: a completed value was lost to a full FIFO

Behaviour:
- Reset (reset low, async): state IDLE, accumulator 0, FIFO empty, out_valid 0, out_value 0, overflow 0, dropped 0. Reset mid-number discards the partial value.
- Byte accepted on a rising edge with rx_avail=1 and enable=1. Other bytes are ignored. FIFO pops continue regardless of enable.
- Digit = 0x30..0x39. CR (0x0D) is ignored in every state.
- Accumulate: acc_next = acc*10 + (byte-0x30), computed at WIDTH+4 bits. If the result is >2^WIDTH-1, acc saturates to all-ones and overflow is set. Later digits keep it saturated.
- States:
  IDLE (no digits): digit -> NUM, acc=digit. TERM -> stay, no push (empty line). Other -> SKIP.
  NUM: digit -> accumulate. TERM -> push acc, acc=0, IDLE. Other -> SKIP, partial value discarded.
  SKIP: TERM -> IDLE, acc=0, no push. Other -> stay.
- Latency: for an empty FIFO, out_valid=1 and out_value=parsed value on the cycle after the edge that accepted TERM.
- FIFO is show-ahead. Pop occurs when out_valid && out_ready. When empty, out_value holds its last value (0 after reset).
- Push when full with no pop: the value is discarded and dropped is set. Push and pop in the same cycle when full: both happen, nothing is lost.
- Push and pop in the same cycle on a one-entry FIFO: head advances to the new value, out_valid stays 1.
- Pointers wrap modulo FIFO_DEPTH. Occupancy counter is log2(FIFO_DEPTH)+1 bits.
- overflow and dropped are cleared only by reset.

Optional Feature:
SERIAL_RX_ECHO_EN:
- Defined: adds input cansend (1) and output echo (9), formatted {byte[7:0], stb} to match the serial transmit path.
- Each accepted byte, including CR and invalid bytes, is loaded into a one-byte echo holding register.
- When the register is full and cansend=1, echo={byte,1'b1} for exactly one cycle and the register empties. Otherwise echo=0.
- A byte arriving while the register is full is not echoed and does not affect parsing.
- Echo reset value is 0 and the holding register resets to empty.
- Not defined: the ports and logic are absent. Parsing behaviour is identical in both builds.

Test Plan:
1. Send "123\n", out_ready=1 -> out_valid pulses 1 cycle after '\n' with out_value=123, overflow=0.
2. WIDTH=32, send "4294967295\n" -> 0xFFFFFFFF, overflow=0. Then send "4294967296\n" -> 0xFFFFFFFF, overflow=1.
3. Send "12a3\n45\r\n\n" -> exactly one value (45) is output. The empty line and the invalid number produce nothing.
4. Hold out_ready=0, send "1\n2\n3\n4\n5\n" (depth 4) -> FIFO full, dropped=1. Then out_ready=1 pops 1,2,3,4, and out_valid falls.
5. Send "98", pulse reset low mid-stream, release, send "7\n" -> single output 7, all flags 0.
6. SERIAL_RX_ECHO_EN defined: cansend=0, send 'A' -> echo=0. Raise cansend -> echo=9'h083 for exactly one cycle, then 0.
